snake_body_ctrl: RTL
====================

Name: snake_body_ctrl

Overview:
- Owns the snake's position state and produces the `headX`/`headY` stream that the food/eat logic consumes.
- Consumes the food logic's `addLength` pulse to grow the snake.
- On each move tick it advances the head by the latched direction, shifts the body segment array, and checks wall and self collisions.
- Provides a per-cell occupancy query for the VGA renderer.

Parameters:
- GRID_W, 40, playfield columns; valid X is 0..GRID_W-1, and GRID_W ≤ 64.
- GRID_H, 30, playfield rows; valid Y is 0..GRID_H-1, and GRID_H ≤ 64.
- MAX_LEN, 16, number of segment registers, which is the maximum length.
- INIT_LEN, 3, length after reset or restart; 1 ≤ INIT_LEN ≤ MAX_LEN.
- START_X, 20, initial head column; START_X ≥ INIT_LEN-1.
- START_Y, 15, initial head row.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- tick  in  1  one-cycle move strobe from the game-speed divider.
- dir_in  in  2  requested direction: 0 up (Y-1), 1 down (Y+1), 2 left (X-1), 3 right (X+1).
- start  in  1  one-cycle start/restart request.
- addLength  in  1  one-cycle grow pulse from the food logic.
- headX  out  6  current head column.
- headY  out  6  current head row.
- length  out  5  current segment count.
- alive  out  1  high while in RUN.
- gameOver  out  1  high while in DEAD.
- qX  in  6  renderer query column.
- qY  in  6  renderer query row.
- qHit  out  1  combinational; 1 when (qX,qY) equals any active segment 0..length-1.

Behaviour:
- Reset (rst low, asynchronous), or restart:
  - segment i = (START_X-i, START_Y) for i < INIT_LEN; all other segments hold (START_X, START_Y).
  - headX = START_X, headY = START_Y.
  - length = INIT_LEN, direction register = right (3).
  - pending grow = 0.
  - State on reset is IDLE: alive = 0, gameOver = 0. State on restart is given under State machine.
- State machine:
  - IDLE: `start` → RUN; `tick` is ignored.
  - RUN: each `tick` performs a move.
  - RUN → DEAD on any collision.
  - DEAD: outputs and segments are frozen; `start` performs restart initialisation and enters RUN in the same edge.
- Direction latch:
  - In RUN, `dir_in` is sampled at every `tick`.
  - A request that is the exact reverse of the current direction is ignored, and the previous direction is kept.
  - The accepted direction applies to the move made at that same tick.
- Move at a tick, all in one clock edge, registered:
  - Compute next = head + direction step.
  - Wall: if next X < 0, next X ≥ GRID_W, next Y < 0 or next Y ≥ GRID_H, enter DEAD. No segment update occurs.
  - Self-collision: if next equals segment k for any k in 0..length-2, enter DEAD.
  - If growing at this move, segment length-1 is also checked.
  - When not growing, the tail cell being vacated is legal.
  - Otherwise: segment[i] ← segment[i-1] for i ≥ 1, and segment[0] ← next.
  - `headX`/`headY` show the new head one cycle after the `tick` edge (latency 1).
- Growth:
  - An `addLength` pulse sets pending grow, and pending grow is held until the next move.
  - At a move with pending grow and length < MAX_LEN: length increments and pending clears. The old tail stays occupied because the shift makes segment[length] valid.
  - At length = MAX_LEN, pending grow is cleared without growing.
  - `addLength` in the same cycle as `tick` counts for that move.
  - Multiple pulses before one move produce a single grow.
  - `addLength` in IDLE or DEAD is ignored.
- Simultaneous `start` and `tick` in IDLE: start wins, and no move occurs that cycle.
- Reset mid-game: immediate asynchronous return to the reset state, including pending grow cleared.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: wall crossings wrap instead of killing.
  - X = -1 → GRID_W-1, X = GRID_W → 0.
  - Same rule for Y against GRID_H.
  - Self-collision still kills.
- Undefined: wall crossing enters DEAD as described above.

Test Plan:
- Reset, then `start`, then 3 ticks with `dir_in`=3 → head (20,15) → (21,15) → (22,15) → (23,15); length stays 3; alive = 1.
- While heading right, tick with `dir_in`=2 → reversal ignored; head moves to X+1; then `dir_in`=0 tick → Y decreases by 1.
- `addLength` pulse, then one tick → length 3→4; qHit = 1 at the old tail cell; a second tick without a pulse keeps length 4.
- Steer into the right wall (head X=39, dir right, tick) → gameOver = 1, alive = 0, head stays (39,y). Further ticks change nothing. `start` → head (20,15), length 3, RUN.
- With length 5, turn up, left, down in successive ticks → head hits its own body → DEAD. Separately, with length 4 and no grow, a 2x2 loop chasing the tail stays alive.
- Assert rst low mid-RUN at length 6 → asynchronously length = 3, head (20,15), alive = 0. With SNAKE_WRAP_EN, X=39 moving right → X=0 and alive remains 1.

Source files
------------

// File: rtl/snake_body_ctrl.sv
// Snake body controller: owns the segment array, moves the head on each tick, grows on food,
// detects wall/self collisions, and answers per-cell occupancy queries. Optional macro: SNAKE_WRAP_EN.
module snake_body_ctrl #(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 20,
    parameter int START_Y  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [1:0] dir_in,
    input  logic       start,
    input  logic       addLength,
    output logic [5:0] headX,
    output logic [5:0] headY,
    output logic [4:0] length,
    output logic       alive,
    output logic       gameOver,
    input  logic [5:0] qX,
    input  logic [5:0] qY,
    output logic       qHit
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t     state, stateNext;
    logic [5:0] segX [MAX_LEN];
    logic [5:0] segY [MAX_LEN];
    logic [4:0] len;
    logic [1:0] dir;
    logic       growPend;

    logic [1:0] moveDir;
    logic [5:0] nextX, nextY;
    logic       wallHit, selfHit;
    logic       growNow;
    logic       doMove, doInit;

    // Direction, next head cell and collision detection
    always_comb begin
        moveDir = dir_in;
        nextX   = segX[0];
        nextY   = segY[0];
        wallHit = 1'b0;
        selfHit = 1'b0;
        growNow = 1'b0;

        // Exact reversal flips only the low bit within the up/down or left/right pair
        if (dir_in == {dir[1], ~dir[0]}) begin
            moveDir = dir;
        end

        case (moveDir)
            2'd0: begin
                if (segY[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    nextY = 6'(GRID_H - 1);
`else
                    wallHit = 1'b1;
`endif
                end else begin
                    nextY = segY[0] - 6'd1;
                end
            end
            2'd1: begin
                if (segY[0] == 6'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    nextY = '0;
`else
                    wallHit = 1'b1;
`endif
                end else begin
                    nextY = segY[0] + 6'd1;
                end
            end
            2'd2: begin
                if (segX[0] == '0) begin
`ifdef SNAKE_WRAP_EN
                    nextX = 6'(GRID_W - 1);
`else
                    wallHit = 1'b1;
`endif
                end else begin
                    nextX = segX[0] - 6'd1;
                end
            end
            default: begin
                if (segX[0] == 6'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    nextX = '0;
`else
                    wallHit = 1'b1;
`endif
                end else begin
                    nextX = segX[0] + 6'd1;
                end
            end
        endcase

        growNow = (growPend || addLength) && (len < 5'(MAX_LEN));

        // The tail cell is only blocked when it stays occupied, i.e. when growing
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (segX[k] == nextX && segY[k] == nextY &&
                ((k + 1 < 32'(len)) || (growNow && (k + 1 == 32'(len))))) begin
                selfHit = 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        doMove    = 1'b0;
        doInit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (tick) begin
                    if (wallHit || selfHit) begin
                        stateNext = DEAD;
                    end else begin
                        doMove = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (start) begin
                    stateNext = RUN;
                    doInit    = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                segX[i] <= (i < INIT_LEN) ? 6'(START_X - int'(i)) : 6'(START_X);
                segY[i] <= 6'(START_Y);
            end
            len      <= 5'(INIT_LEN);
            dir      <= 2'd3;
            growPend <= 1'b0;
        end else if (doInit) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                segX[i] <= (i < INIT_LEN) ? 6'(START_X - int'(i)) : 6'(START_X);
                segY[i] <= 6'(START_Y);
            end
            len      <= 5'(INIT_LEN);
            dir      <= 2'd3;
            growPend <= 1'b0;
        end else if (doMove) begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                segX[i] <= segX[i-1];
                segY[i] <= segY[i-1];
            end
            segX[0]  <= nextX;
            segY[0]  <= nextY;
            dir      <= moveDir;
            growPend <= 1'b0;
            if (growNow) begin
                len <= len + 5'd1;
            end
        end else if (state == RUN && addLength) begin
            growPend <= 1'b1;
        end
    end

    always_comb begin
        qHit = 1'b0;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (k < 32'(len) && segX[k] == qX && segY[k] == qY) begin
                qHit = 1'b1;
            end
        end
    end

    assign headX    = segX[0];
    assign headY    = segY[0];
    assign length   = len;
    assign alive    = (state == RUN);
    assign gameOver = (state == DEAD);

endmodule
